// File: rtl/nibble_serial_adder_pkg.sv
// Shared ALU definitions: sequencer state encodings and the nibble width
// used by the nibble-serial add/subtract unit.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_cla4.sv
// 4-bit carry-lookahead unit: all four nibble carries from per-bit
// generate/propagate and the incoming carry, with no ripple between bits.
module nibble_serial_adder_cla4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] g_i,
    input  logic [NIBBLE_W-1:0] p_i,
    input  logic                c_i,
    output logic [NIBBLE_W-1:0] c_o
);

    // Flattened lookahead equations for each carry out of bit k
    always_comb begin
        c_o[0] = g_i[0] | (p_i[0] & c_i);
        c_o[1] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
        c_o[2] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
               | (p_i[2] & p_i[1] & p_i[0] & c_i);
        c_o[3] = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
               | (p_i[3] & p_i[2] & p_i[1] & g_i[0])
               | (p_i[3] & p_i[2] & p_i[1] & p_i[0] & c_i);
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract: one nibble per clock through a shared
// CLA4, with the nibble carry-out registered as the next carry-in.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             zero_o
);

    localparam int N_NIB = WIDTH / NIBBLE_W;
    localparam int CNT_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(N_NIB - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [NIBBLE_W-1:0] g_s, p_s, c_s, sum_nib_s;
    logic [WIDTH-1:0]    nib_ext_s, sum_shift_s;

    nibble_serial_adder_cla4 u_cla4 (
        .g_i (g_s),
        .p_i (p_s),
        .c_i (carry_q),
        .c_o (c_s)
    );

    // Per-nibble G/P, sum formation and the sum register shifted from the top
    always_comb begin
        g_s         = a_q[NIBBLE_W-1:0] & b_q[NIBBLE_W-1:0];
        p_s         = a_q[NIBBLE_W-1:0] ^ b_q[NIBBLE_W-1:0];
        sum_nib_s   = p_s ^ {c_s[2:0], carry_q};
        nib_ext_s   = '0;
        nib_ext_s[WIDTH-1 -: NIBBLE_W] = sum_nib_s;
        sum_shift_s = (sum_q >> NIBBLE_W) | nib_ext_s;
    end

    // Sequencer next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    state_d = ST_RUN;
                    a_d     = a_i;
                    b_d     = b_i ^ {WIDTH{sub_i}};
                    carry_d = sub_i;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                carry_d = c_s[3];
                sum_d   = sum_shift_s;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_NIB) begin
                    state_d = ST_DONE;
                    cout_d  = c_s[3];
                    ovf_d   = c_s[3] ^ c_s[2];
                    zero_d  = (sum_shift_s == '0);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                // Returning to IDLE never accepts in the same edge
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign overflow_o  = ovf_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH=32 and WIDTH=8.
module tb_nibble_serial_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv32 = 1'b0, ir32, sub32 = 1'b0, ov32, or32 = 1'b0, co32, vf32, z32;
    logic [31:0] a32 = 32'd0, b32 = 32'd0, s32;
    logic        iv8 = 1'b0, ir8, sub8 = 1'b0, ov8, or8 = 1'b0, co8, vf8, z8;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0, s8;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q32[$];
    exp_t q8[$];

    nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv32), .in_ready_o(ir32),
        .a_i(a32), .b_i(b32), .sub_i(sub32), .out_valid_o(ov32),
        .out_ready_i(or32), .sum_o(s32), .cout_o(co32), .overflow_o(vf32),
        .zero_o(z32)
    );

    nibble_serial_adder #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv8), .in_ready_o(ir8),
        .a_i(a8), .b_i(b8), .sub_i(sub8), .out_valid_o(ov8),
        .out_ready_i(or8), .sum_o(s8), .cout_o(co8), .overflow_o(vf8),
        .zero_o(z8)
    );

    function automatic exp_t model(input int w, input logic [31:0] a,
                                   input logic [31:0] b, input logic sub);
        exp_t        r;
        logic [32:0] full;
        logic [31:0] msk, bb;
        msk    = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        a      = a & msk;
        bb     = (sub ? ~b : b) & msk;
        full   = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
        r.sum  = full[31:0] & msk;
        r.cout = full[w];
        r.ovf  = (a[w-1] == bb[w-1]) && (r.sum[w-1] != a[w-1]);
        r.zero = (r.sum == 32'd0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int guard = 0;
        while (!ir32 && guard < 20) begin tick(); guard++; end
        n_cmp++;
        if (ir32 !== 1'b1) begin
            n_bad++;
            $display("FAIL start32_ready: in_ready=%0b required 1", ir32);
        end
        a32 = a; b32 = b; sub32 = sub; iv32 = 1'b1;
        tick();
        iv32 = 1'b0;
        q32.push_back(model(32, a, b, sub));
    endtask

    task automatic finish32(input string tag, input int hold, input bit release_it);
        int   lat = 0;
        exp_t e;
        while (!ov32 && lat < 40) begin tick(); lat++; end
        n_cmp++;
        if (lat !== 8) begin
            n_bad++;
            $display("FAIL %s latency: got %0d cycles required 8", tag, lat);
        end
        if (q32.size() == 0) begin
            n_bad++;
            $display("FAIL %s scoreboard: queue empty, required one entry", tag);
            return;
        end
        e = q32.pop_front();
        n_cmp++;
        if ({s32, co32, vf32, z32} !== {e.sum, e.cout, e.ovf, e.zero}) begin
            n_bad++;
            $display("FAIL %s result: sum=%h c=%0b v=%0b z=%0b required sum=%h c=%0b v=%0b z=%0b",
                     tag, s32, co32, vf32, z32, e.sum, e.cout, e.ovf, e.zero);
        end
        if (release_it) begin
            repeat (hold) tick();
            or32 = 1'b1;
            tick();
            or32 = 1'b0;
            n_cmp++;
            if (ir32 !== 1'b1 || ov32 !== 1'b0) begin
                n_bad++;
                $display("FAIL %s release: in_ready=%0b out_valid=%0b required 1/0", tag, ir32, ov32);
            end
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sub);
        int   lat = 0;
        exp_t e;
        a8 = a; b8 = b; sub8 = sub; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        q8.push_back(model(8, {24'd0, a}, {24'd0, b}, sub));
        while (!ov8 && lat < 20) begin tick(); lat++; end
        n_cmp++;
        if (lat !== 2) begin
            n_bad++;
            $display("FAIL %s latency: got %0d cycles required 2", tag, lat);
        end
        e = q8.pop_front();
        n_cmp++;
        if ({s8, co8, vf8, z8} !== {e.sum[7:0], e.cout, e.ovf, e.zero}) begin
            n_bad++;
            $display("FAIL %s result: sum=%h c=%0b v=%0b z=%0b required sum=%h c=%0b v=%0b z=%0b",
                     tag, s8, co8, vf8, z8, e.sum[7:0], e.cout, e.ovf, e.zero);
        end
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_cmp++;
        if ({ir32, ov32, s32, co32, vf32, z32} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset32: rdy=%0b vld=%0b sum=%h c=%0b v=%0b z=%0b required 1 0 0 0 0 0",
                     ir32, ov32, s32, co32, vf32, z32);
        end
        n_cmp++;
        if ({ir8, ov8, s8, co8, vf8, z8} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset8: rdy=%0b vld=%0b sum=%h required 1 0 00", ir8, ov8, s8);
        end
    endtask

    task automatic test_directed();
        start32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0); finish32("add_wrap", 0, 1'b1);
        start32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); finish32("add_ovf", 1, 1'b1);
        start32(32'd5, 32'd7, 1'b1);                 finish32("sub_neg", 0, 1'b1);
        start32(32'h8000_0000, 32'd1, 1'b1);         finish32("sub_ovf", 2, 1'b1);
        start32(32'd9, 32'd9, 1'b1);                 finish32("sub_zero", 0, 1'b1);
    endtask

    task automatic test_backpressure();
        exp_t e;
        e = model(32, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        start32(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        finish32("bp_first", 0, 1'b0);
        a32 = 32'h0000_0001; b32 = 32'h0000_0001; sub32 = 1'b1; iv32 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({ov32, ir32, s32, co32, vf32, z32} !== {1'b1, 1'b0, e.sum, e.cout, e.ovf, e.zero}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: vld=%0b rdy=%0b sum=%h required 1 0 %h", i, ov32, ir32, s32, e.sum);
            end
        end
        or32 = 1'b1;
        tick();
        or32 = 1'b0;
        iv32 = 1'b0;
        n_cmp++;
        if ({ir32, ov32, s32, co32, vf32, z32} !== {1'b1, 1'b0, e.sum, e.cout, e.ovf, e.zero}) begin
            n_bad++;
            $display("FAIL bp_release: rdy=%0b vld=%0b sum=%h required 1 0 %h", ir32, ov32, s32, e.sum);
        end
        tick();
        n_cmp++;
        if (ir32 !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_no_turnaround: in_ready=%0b required 1", ir32);
        end
    endtask

    task automatic test_reset_mid_run();
        start32(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(q32.pop_back());
        n_cmp++;
        if ({ir32, ov32, s32, co32, vf32, z32} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_reset: rdy=%0b vld=%0b sum=%h c=%0b v=%0b z=%0b required 1 0 0 0 0 0",
                     ir32, ov32, s32, co32, vf32, z32);
        end
        start32(32'h1234_5678, 32'h1111_1111, 1'b0);
        finish32("after_reset", 0, 1'b1);
        n_cmp++;
        if (s32 !== 32'h2345_6789) begin
            n_bad++;
            $display("FAIL after_reset_const: sum=%h required 23456789", s32);
        end
    endtask

    task automatic test_width8();
        op8("w8_wrap", 8'hF0, 8'h10, 1'b0);
        n_cmp++;
        if ({s8, co8, z8} !== {8'h00, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL w8_wrap_const: sum=%h c=%0b z=%0b required 00 1 1", s8, co8, z8);
        end
        op8("w8_sub", 8'h80, 8'h01, 1'b1);
        for (int i = 0; i < 200; i++) begin
            op8("w8_rand", 8'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 4) == 0) ? a : $urandom;
            start32(a, b, 1'($urandom));
            finish32("rand32", $urandom_range(0, 2), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_width8();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
